// File: rtl/decim_asmd_param.sv
// Parametrised decimate-by-FACTOR accumulate-and-dump / pick-last controller.
// Holds each completed result until ld, and stalls input while it waits.
module decim_asmd_param #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int FACTOR = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    input  logic              clr,
    input  logic              ld,
    output logic              in_ready,
    output logic [OUT_W-1:0]  r0,
    output logic              r0_valid,
    output logic              busy
);
    localparam int CNT_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t            state, state_n;
    logic [OUT_W-1:0]  acc, acc_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [OUT_W-1:0]  r0_n;
    logic              valid_n;
    logic [OUT_W-1:0]  ext;
    logic [CNT_W:0]    cnt_inc;
    logic              accept;

    assign ext      = (SIGNED != 0) ? OUT_W'($signed(data)) : OUT_W'(data);
    assign cnt_inc  = {1'b0, cnt} + 1'b1;
    assign in_ready = (state != FULL) || ld;
    assign accept   = en && in_ready && !clr;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            r0       <= '0;
            r0_valid <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            r0       <= r0_n;
            r0_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        r0_n    = r0;
        valid_n = 1'b0;
        if (clr) begin
            // Flush wins over both a new sample and a pending drain.
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (state == IDLE)
                            acc_n = ext;
                        else
                            acc_n = mode ? ext : acc + ext;
                        if (cnt_inc == (CNT_W+1)'(FACTOR)) begin
                            cnt_n   = '0;
                            state_n = FULL;
                        end else begin
                            cnt_n   = cnt_inc[CNT_W-1:0];
                            state_n = COLLECT;
                        end
                    end
                end
                FULL: begin
                    if (ld) begin
                        r0_n    = acc;
                        valid_n = 1'b1;
                        if (en) begin
                            acc_n   = ext;
                            cnt_n   = CNT_W'(1);
                            state_n = COLLECT;
                        end else begin
                            acc_n   = '0;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
